// File: rtl/dcache_stub_responder.sv
// Stub data-cache responder: in-order response FIFO with fixed latency over a small backing memory.
// Optional random request stalls enabled by defining DCACHE_STUB_STALL_EN.
module dcache_stub_responder #(
  parameter int LATENCY            = 2,
  parameter int MEM_WORDS          = 256,
  parameter int OUTST              = 4,
  parameter int XLEN               = 64,
  parameter int VIRTUAL_ADDR_LEN   = 32,
  parameter int LSU_LSQ_SIZE_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_opcode_i,
  input  logic                          req_sign_i,
  input  logic [1:0]                    req_size_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]               req_data_i,
  input  logic [LSU_LSQ_SIZE_WIDTH-1:0] req_lsq_index_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [LSU_LSQ_SIZE_WIDTH-1:0] resp_lsq_index_o,
  output logic [XLEN-1:0]               resp_data_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OUTST);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  logic [XLEN-1:0]               mem       [MEM_WORDS];
  logic [XLEN-1:0]               fifo_data [OUTST];
  logic [LSU_LSQ_SIZE_WIDTH-1:0] fifo_tag  [OUTST];
  logic [2:0]                    fifo_cnt  [OUTST];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [PTR_W:0]                count;
  logic                          accept, drain, stall;
  logic [IDX_W-1:0]              word_idx;
  logic [2:0]                    off;
  logic                          unused_addr;

  function automatic logic [2:0] align_off(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'd0:    return a;
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [2:0] o,
                                                   input logic [1:0] size,
                                                   input logic sgn);
    logic [XLEN-1:0] s;
    s = word >> {o, 3'b000};
    case (size)
      2'd0:    return {{(XLEN-8){sgn & s[7]}}, s[7:0]};
      2'd1:    return {{(XLEN-16){sgn & s[15]}}, s[15:0]};
      2'd2:    return {{(XLEN-32){sgn & s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] data,
                                                  input logic [2:0] o,
                                                  input logic [1:0] size);
    logic [XLEN-1:0] m;
    case (size)
      2'd0:    m = XLEN'(8'hFF);
      2'd1:    m = XLEN'(16'hFFFF);
      2'd2:    m = XLEN'(32'hFFFF_FFFF);
      default: m = '1;
    endcase
    m = m << {o, 3'b000};
    return (old & ~m) | ((data << {o, 3'b000}) & m);
  endfunction

`ifdef DCACHE_STUB_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign word_idx    = req_addr_i[3 +: IDX_W];
  assign off         = align_off(req_addr_i[2:0], req_size_i);
  assign unused_addr = ^req_addr_i[VIRTUAL_ADDR_LEN-1:3+IDX_W];

  // Credit only from the registered count: a drain this cycle frees a slot next cycle.
  assign req_ready_o  = rstn && (count != FULL_CNT) && !stall;
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (count != '0) && (fifo_cnt[rd_ptr] == 3'd0);
  assign drain        = resp_valid_o && resp_ready_i;

  assign resp_data_o      = resp_valid_o ? fifo_data[rd_ptr] : '0;
  assign resp_lsq_index_o = resp_valid_o ? fifo_tag[rd_ptr]  : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUTST; i++) fifo_cnt[i] <= 3'd0;
    end else begin
      // Every entry counts down regardless of position so queued responses mature while blocked.
      for (int i = 0; i < OUTST; i++) begin
        if (accept && (wr_ptr == PTR_W'(i)))
          fifo_cnt[i] <= CNT_INIT;
        else if (fifo_cnt[i] != 3'd0)
          fifo_cnt[i] <= fifo_cnt[i] - 3'd1;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (drain)  rd_ptr <= rd_ptr + 1'b1;
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_data[wr_ptr] <= req_opcode_i ? '0
                         : load_extract(mem[word_idx], off, req_size_i, req_sign_i);
      fifo_tag[wr_ptr]  <= req_lsq_index_i;
      if (req_opcode_i)
        mem[word_idx] <= store_merge(mem[word_idx], req_data_i, off, req_size_i);
    end
  end

endmodule
